// File: rtl/branch_pkg.sv
// Shared types and helpers for the branch predict unit: BTB entry layout,
// 2-bit counter encodings and the saturating counter update.
package branch_pkg;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  // Tag and target are held at full address width; bits above PC_W stay zero.
  typedef struct packed {
    logic        valid;
    logic [31:0] tag;
    logic [31:0] target;
    logic [1:0]  cnt;
  } btb_entry_t;

  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != CNT_ST) nxt = cnt + 2'd1;
      else               nxt = cnt;
    end else begin
      if (cnt != CNT_SNT) nxt = cnt - 2'd1;
      else                nxt = cnt;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/btb_table.sv
// Direct-mapped BTB storage: fetch-side lookup port, EX-side lookup port and
// a single write port. Reads are combinational from the entry flops.
module btb_table
  import branch_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output btb_entry_t       rd_entry,
  input  logic [IDX_W-1:0] ex_idx,
  output btb_entry_t       ex_entry,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  btb_entry_t       wr_entry
);

  btb_entry_t table_r [ENTRIES];

  assign rd_entry = table_r[rd_idx];
  assign ex_entry = table_r[ex_idx];

  // Entry storage: reset clears every entry to invalid / weakly-not-taken.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_r[i] <= '{valid: 1'b0, tag: 32'd0, target: 32'd0, cnt: CNT_WNT};
      end
    end else if (wr_en) begin
      table_r[wr_idx] <= wr_entry;
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch predict unit: BTB lookup for IF, combinational branch/jump resolution
// for EX with redirect on mispredict, BTB training and performance counters.
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int PC_W    = 9,
  parameter int ENTRIES = 16,
  parameter int PERF_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PC_W-1:0]   if_pc,
  output logic              pred_taken,
  output logic [PC_W-1:0]   pred_target,
  input  logic              ex_valid,
  input  logic [PC_W-1:0]   Cur_PC,
  input  logic [31:0]       Imm,
  input  logic              Branch,
  input  logic              JSel,
  input  logic              JrSel,
  input  logic [31:0]       AluResult,
  input  logic              ex_pred_taken,
  input  logic [PC_W-1:0]   ex_pred_tgt,
  output logic [31:0]       PC_Imm,
  output logic [31:0]       PC_Four,
  output logic [31:0]       BrPC,
  output logic              PcSel,
  output logic [PERF_W-1:0] perf_branches,
  output logic [PERF_W-1:0] perf_mispred
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [IDX_W-1:0]  if_idx_s, ex_idx_s;
  logic [31:0]       if_tag_s, ex_tag_s;
  btb_entry_t        if_entry_s, ex_entry_s, wr_entry_s;
  logic              if_hit_s, ex_hit_s, wr_en_s;
  logic              ctl_s, jump_s, act_taken_s, mis_s;
  logic [PC_W-1:0]   act_tgt_s;
  logic [PERF_W-1:0] perf_branches_r, perf_mispred_r;

  // A zero-width tag shifts out every PC bit, so the tag compares equal to 0.
  assign if_idx_s = if_pc[IDX_W+1:2];
  assign ex_idx_s = Cur_PC[IDX_W+1:2];
  assign if_tag_s = 32'(if_pc >> (IDX_W + 2));
  assign ex_tag_s = 32'(Cur_PC >> (IDX_W + 2));

  btb_table #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_btb (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (if_idx_s),
    .rd_entry (if_entry_s),
    .ex_idx   (ex_idx_s),
    .ex_entry (ex_entry_s),
    .wr_en    (wr_en_s),
    .wr_idx   (ex_idx_s),
    .wr_entry (wr_entry_s)
  );

  assign if_hit_s    = if_entry_s.valid && (if_entry_s.tag == if_tag_s);
  assign ex_hit_s    = ex_entry_s.valid && (ex_entry_s.tag == ex_tag_s);
  assign pred_taken  = if_hit_s && (if_entry_s.cnt >= CNT_WT);
  assign pred_target = if_hit_s ? PC_W'(if_entry_s.target) : if_pc + PC_W'(4);

  assign PC_Imm      = 32'(Cur_PC) + Imm;
  assign PC_Four     = 32'(Cur_PC) + 32'd4;
  assign ctl_s       = Branch | JSel | JrSel;
  assign jump_s      = JSel | JrSel;
  assign act_taken_s = jump_s | (Branch & AluResult[0]);
  assign act_tgt_s   = JrSel ? PC_W'(AluResult & ~32'd1) : PC_W'(PC_Imm);

  // A non-control instruction predicted taken is a BTB alias and must redirect too.
  assign mis_s = ex_valid & (ctl_s ? ((act_taken_s != ex_pred_taken) |
                                      (act_taken_s & (act_tgt_s != ex_pred_tgt)))
                                   : ex_pred_taken);
  assign PcSel = mis_s;
  assign BrPC  = mis_s ? (act_taken_s ? 32'(act_tgt_s) : PC_Four) : 32'd0;

  // Training write for the EX instruction: counter update, allocation or alias invalidation.
  always_comb begin
    wr_en_s    = 1'b0;
    wr_entry_s = ex_entry_s;
    if (ex_valid && ctl_s) begin
      if (ex_hit_s) begin
        wr_en_s = 1'b1;
        if (jump_s) wr_entry_s.cnt = CNT_ST;
        else        wr_entry_s.cnt = sat_update(ex_entry_s.cnt, act_taken_s);
        if (act_taken_s) wr_entry_s.target = 32'(act_tgt_s);
        else             wr_entry_s.target = ex_entry_s.target;
      end else if (act_taken_s) begin
        wr_en_s    = 1'b1;
        wr_entry_s = '{valid: 1'b1, tag: ex_tag_s, target: 32'(act_tgt_s),
                       cnt: (jump_s ? CNT_ST : CNT_WT)};
      end else begin
        wr_en_s = 1'b0;
      end
    end else if (ex_valid && ex_pred_taken && ex_hit_s) begin
      wr_en_s          = 1'b1;
      wr_entry_s.valid = 1'b0;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Performance counters wrap naturally at 2^PERF_W.
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_branches_r <= '0;
      perf_mispred_r  <= '0;
    end else begin
      perf_branches_r <= perf_branches_r + PERF_W'(ex_valid & ctl_s);
      perf_mispred_r  <= perf_mispred_r + PERF_W'(mis_s);
    end
  end

  assign perf_branches = perf_branches_r;
  assign perf_mispred  = perf_mispred_r;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Bench for branch_predict_unit: directed vector table, reset/idle sequences,
// then randomized traffic against an array-based reference model.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  if_pc;
  logic        pred_taken;
  logic [8:0]  pred_target;
  logic        ex_valid;
  logic [8:0]  Cur_PC;
  logic [31:0] Imm;
  logic        Branch, JSel, JrSel;
  logic [31:0] AluResult;
  logic        ex_pred_taken;
  logic [8:0]  ex_pred_tgt;
  logic [31:0] PC_Imm, PC_Four, BrPC;
  logic        PcSel;
  logic [31:0] perf_branches, perf_mispred;

  int n_cmp = 0;
  int n_bad = 0;

  branch_predict_unit #(.PC_W(9), .ENTRIES(16), .PERF_W(32)) dut (
    .clk(clk), .reset(reset), .if_pc(if_pc), .pred_taken(pred_taken),
    .pred_target(pred_target), .ex_valid(ex_valid), .Cur_PC(Cur_PC), .Imm(Imm),
    .Branch(Branch), .JSel(JSel), .JrSel(JrSel), .AluResult(AluResult),
    .ex_pred_taken(ex_pred_taken), .ex_pred_tgt(ex_pred_tgt), .PC_Imm(PC_Imm),
    .PC_Four(PC_Four), .BrPC(BrPC), .PcSel(PcSel),
    .perf_branches(perf_branches), .perf_mispred(perf_mispred)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ev, input logic [8:0] pc, input logic [31:0] imm,
                       input logic br, input logic jal, input logic jalr,
                       input logic [31:0] alu, input logic ept, input logic [8:0] eptt,
                       input logic [8:0] ipc);
    ex_valid = ev; Cur_PC = pc; Imm = imm; Branch = br; JSel = jal; JrSel = jalr;
    AluResult = alu; ex_pred_taken = ept; ex_pred_tgt = eptt; if_pc = ipc;
  endtask

  typedef struct {
    logic        ev;
    logic [8:0]  pc;
    logic [31:0] imm;
    logic        br, jal, jalr;
    logic [31:0] alu;
    logic        ept;
    logic [8:0]  eptt;
    logic [8:0]  ipc;
    logic        e_sel;
    logic [31:0] e_brpc;
    logic        e_pt;
    logic [8:0]  e_ptgt;
  } vec_t;

  vec_t vecs[17];

  // Reference model: plain arrays indexed by (pc/4)%16, tag = pc/64.
  bit          m_v[16];
  int unsigned m_tag[16], m_tgt[16], m_cnt[16];
  int unsigned m_br, m_mis;

  function automatic void m_reset();
    for (int i = 0; i < 16; i++) begin
      m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_cnt[i] = 1;
    end
    m_br = 0; m_mis = 0;
  endfunction

  function automatic void m_predict(input int unsigned pc, output bit pt, output int unsigned tg);
    int unsigned idx;
    bit hit;
    idx = (pc / 4) % 16;
    hit = m_v[idx] && (m_tag[idx] == pc / 64);
    pt  = hit && (m_cnt[idx] >= 2);
    tg  = hit ? m_tgt[idx] : (pc + 4) % 512;
  endfunction

  initial begin
    logic [31:0] pcimm, pcfour, alu, imm, brpc;
    int unsigned pc, ipc, typ, idx, tgt, exp_tg, eptt;
    bit ev, ept, rst, ctl, taken, mis, hit, exp_pt;

    vecs[0]  = '{1'b1, 9'h040, 32'h20, 1'b1, 1'b0, 1'b0, 32'h1,  1'b0, 9'h000, 9'h040, 1'b1, 32'h60, 1'b0, 9'h044};
    vecs[1]  = '{1'b1, 9'h040, 32'h20, 1'b1, 1'b0, 1'b0, 32'h1,  1'b1, 9'h060, 9'h040, 1'b0, 32'h0,  1'b1, 9'h060};
    vecs[2]  = vecs[1];
    vecs[3]  = vecs[1];
    vecs[4]  = '{1'b1, 9'h040, 32'h20, 1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 9'h060, 9'h040, 1'b1, 32'h44, 1'b1, 9'h060};
    vecs[5]  = '{1'b0, 9'h040, 32'h20, 1'b1, 1'b0, 1'b0, 32'h1,  1'b0, 9'h000, 9'h040, 1'b0, 32'h0,  1'b1, 9'h060};
    vecs[6]  = vecs[4];
    vecs[7]  = '{1'b0, 9'h040, 32'h20, 1'b1, 1'b0, 1'b0, 32'h1,  1'b0, 9'h000, 9'h040, 1'b0, 32'h0,  1'b0, 9'h060};
    vecs[8]  = '{1'b1, 9'h080, 32'h10, 1'b0, 1'b0, 1'b1, 32'hF5, 1'b0, 9'h000, 9'h080, 1'b1, 32'hF4, 1'b0, 9'h084};
    vecs[9]  = '{1'b0, 9'h080, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 9'h000, 9'h080, 1'b0, 32'h0,  1'b1, 9'h0F4};
    vecs[10] = '{1'b0, 9'h080, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 9'h000, 9'h040, 1'b0, 32'h0,  1'b0, 9'h044};
    vecs[11] = '{1'b1, 9'h080, 32'h40, 1'b0, 1'b1, 1'b0, 32'h0,  1'b1, 9'h0F4, 9'h080, 1'b1, 32'hC0, 1'b1, 9'h0F4};
    vecs[12] = '{1'b1, 9'h080, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,  1'b1, 9'h0C0, 9'h080, 1'b1, 32'h84, 1'b1, 9'h0C0};
    vecs[13] = '{1'b0, 9'h080, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 9'h000, 9'h080, 1'b0, 32'h0,  1'b0, 9'h084};
    vecs[14] = '{1'b0, 9'h1FC, 32'hFFFFFFF0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 9'h000, 9'h1FC, 1'b0, 32'h0, 1'b0, 9'h000};
    vecs[15] = '{1'b1, 9'h100, 32'h20, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 9'h000, 9'h100, 1'b0, 32'h0,  1'b0, 9'h104};
    vecs[16] = '{1'b0, 9'h100, 32'h20, 1'b1, 1'b0, 1'b0, 32'h1,  1'b0, 9'h000, 9'h100, 1'b0, 32'h0,  1'b0, 9'h104};

    reset = 1'b0;
    drive(1'b0, 9'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 9'h0, 9'h040);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #4;
    chk("rst_pred_taken", 32'(pred_taken), 32'h0);
    chk("rst_pred_target", 32'(pred_target), 32'h044);
    chk("rst_perf_br", perf_branches, 32'h0);
    chk("rst_perf_mis", perf_mispred, 32'h0);
    chk("rst_pcsel", 32'(PcSel), 32'h0);

    foreach (vecs[i]) begin
      drive(vecs[i].ev, vecs[i].pc, vecs[i].imm, vecs[i].br, vecs[i].jal, vecs[i].jalr,
            vecs[i].alu, vecs[i].ept, vecs[i].eptt, vecs[i].ipc);
      #4;
      chk($sformatf("vec%0d_pcsel", i), 32'(PcSel), 32'(vecs[i].e_sel));
      chk($sformatf("vec%0d_brpc", i), BrPC, vecs[i].e_brpc);
      chk($sformatf("vec%0d_pred_taken", i), 32'(pred_taken), 32'(vecs[i].e_pt));
      chk($sformatf("vec%0d_pred_target", i), 32'(pred_target), 32'(vecs[i].e_ptgt));
      chk($sformatf("vec%0d_pc_four", i), PC_Four, 32'(vecs[i].pc) + 32'd4);
      chk($sformatf("vec%0d_pc_imm", i), PC_Imm, 32'(vecs[i].pc) + vecs[i].imm);
      @(posedge clk);
      #1;
    end
    chk("table_perf_br", perf_branches, 32'd9);
    chk("table_perf_mis", perf_mispred, 32'd6);

    // Reset wins over a taken branch in EX: no allocation, counters cleared.
    reset = 1'b0;
    drive(1'b1, 9'h140, 32'h20, 1'b1, 1'b0, 1'b0, 32'h1, 1'b0, 9'h0, 9'h140);
    #4 chk("rstbr_pcsel", 32'(PcSel), 32'h1);
    @(posedge clk);
    #1 reset = 1'b1;
    drive(1'b0, 9'h140, 32'h20, 1'b1, 1'b0, 1'b0, 32'h1, 1'b0, 9'h0, 9'h140);
    #4;
    chk("rstbr_pred_taken", 32'(pred_taken), 32'h0);
    chk("rstbr_pred_target", 32'(pred_target), 32'h144);
    chk("rstbr_perf_br", perf_branches, 32'h0);
    chk("rstbr_perf_mis", perf_mispred, 32'h0);
    chk("idle_pcsel", 32'(PcSel), 32'h0);
    chk("idle_brpc", BrPC, 32'h0);
    @(posedge clk);
    #5;
    chk("idle_pred_taken", 32'(pred_taken), 32'h0);
    chk("idle_perf_br", perf_branches, 32'h0);

    // Randomized traffic against the model; start from a clean reset.
    reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    m_reset();
    for (int k = 0; k < 500; k++) begin
      pc  = ((($urandom % 4) << 6) | (($urandom % 4) << 2)) + (($urandom % 2) << 8);
      ipc = ((($urandom % 4) << 6) | (($urandom % 4) << 2)) + (($urandom % 2) << 8);
      typ = $urandom % 4;
      ev  = ($urandom % 8) != 0;
      rst = ($urandom % 50) != 0;
      imm = 32'($urandom_range(0, 63) * 4) - 32'd128;
      alu = $urandom;
      m_predict(pc, ept, exp_tg);
      eptt = exp_tg;
      if ($urandom % 5 == 0) begin
        ept  = $urandom % 2;
        eptt = $urandom % 512;
      end
      reset = rst;
      drive(ev, 9'(pc), imm, typ == 1, typ == 2, typ == 3, alu, ept, 9'(eptt), 9'(ipc));
      #4;
      ctl    = typ != 0;
      taken  = (typ >= 2) || (typ == 1 && alu[0]);
      pcimm  = pc + imm;
      pcfour = pc + 4;
      tgt    = (typ == 3) ? (alu & 32'hFFFFFFFE) % 512 : pcimm % 512;
      mis    = ev && (ctl ? ((taken != ept) || (taken && tgt != eptt)) : ept);
      brpc   = mis ? (taken ? 32'(tgt) : pcfour) : 32'h0;
      m_predict(ipc, exp_pt, exp_tg);
      chk("rnd_pred_taken", 32'(pred_taken), 32'(exp_pt));
      chk("rnd_pred_target", 32'(pred_target), exp_tg);
      chk("rnd_pcsel", 32'(PcSel), 32'(mis));
      chk("rnd_brpc", BrPC, brpc);
      chk("rnd_pc_four", PC_Four, pcfour);
      chk("rnd_pc_imm", PC_Imm, pcimm);
      @(posedge clk);
      idx = (pc / 4) % 16;
      hit = m_v[idx] && (m_tag[idx] == pc / 64);
      if (!rst) begin
        m_reset();
      end else begin
        if (ev && ctl) begin
          m_br++;
          if (hit) begin
            if (typ >= 2)  m_cnt[idx] = 3;
            else if (taken) m_cnt[idx] = (m_cnt[idx] == 3) ? 3 : m_cnt[idx] + 1;
            else           m_cnt[idx] = (m_cnt[idx] == 0) ? 0 : m_cnt[idx] - 1;
            if (taken) m_tgt[idx] = tgt;
          end else if (taken) begin
            m_v[idx] = 1; m_tag[idx] = pc / 64; m_tgt[idx] = tgt;
            m_cnt[idx] = (typ >= 2) ? 3 : 2;
          end
        end else if (ev && ept && hit) begin
          m_v[idx] = 0;
        end
        if (mis) m_mis++;
      end
      #1;
      chk("rnd_perf_br", perf_branches, m_br);
      chk("rnd_perf_mis", perf_mispred, m_mis);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
